// File: rtl/uart_rx_core.sv
// UART receiver: 8 data bits, no parity, one stop bit, mid-bit sampling from a
// synchronized serial line. Reports good bytes and framing errors as single-cycle pulses.
//
// state     | meaning
// ----------|------------------------------------------------------------
// IDLE      | line idle, waiting for rxd_s to fall
// START     | timing to the middle of the start bit, rejecting glitches
// DATA      | sampling 8 data bits at bit centres, LSB first
// STOP      | timing to the middle of the stop bit, then checking it
// WAIT_IDLE | after a framing error, waiting for the line to return high
module uart_rx_core #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       UART_RXD,
   output logic [7:0] RX_DATA,
   output logic       RX_DONE,
   output logic       RX_FERR,
   output logic       RX_BUSY
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_WAIT_IDLE
   } state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       rx_data, rx_data_nxt;
   logic             rx_done, rx_done_nxt;
   logic             rx_ferr, rx_ferr_nxt;
   logic             rxd_meta, rxd_s;

   // Synchronizer resets to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= UART_RXD;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         rx_data <= '0;
         rx_done <= 1'b0;
         rx_ferr <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         idx     <= idx_nxt;
         shreg   <= shreg_nxt;
         rx_data <= rx_data_nxt;
         rx_done <= rx_done_nxt;
         rx_ferr <= rx_ferr_nxt;
      end
   end

   // Bit timers are down-counters loaded on entry; each phase acts at terminal count.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      idx_nxt     = idx;
      shreg_nxt   = shreg;
      rx_data_nxt = rx_data;
      rx_done_nxt = 1'b0;
      rx_ferr_nxt = 1'b0;
      case (state)
         S_IDLE: begin
            cnt_nxt = '0;
            idx_nxt = '0;
            if (!rxd_s) begin
               state_nxt = S_START;
               cnt_nxt   = CNT_HALF;
            end
         end
         S_START: begin
            if (cnt == '0) begin
               if (!rxd_s) begin
                  state_nxt = S_DATA;
                  cnt_nxt   = CNT_BIT;
                  idx_nxt   = '0;
               end else begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_DATA: begin
            if (cnt == '0) begin
               shreg_nxt[idx] = rxd_s;
               cnt_nxt        = CNT_BIT;
               idx_nxt        = idx + 3'd1;
               if (idx == 3'd7) state_nxt = S_STOP;
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_STOP: begin
            if (cnt == '0) begin
               if (rxd_s) begin
                  rx_data_nxt = shreg;
                  rx_done_nxt = 1'b1;
                  state_nxt   = S_IDLE;
               end else begin
                  rx_ferr_nxt = 1'b1;
                  state_nxt   = S_WAIT_IDLE;
               end
            end else begin
               cnt_nxt = cnt - CNT_W'(1);
            end
         end
         S_WAIT_IDLE: begin
            cnt_nxt = '0;
            if (rxd_s) state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   assign RX_DATA = rx_data;
   assign RX_DONE = rx_done;
   assign RX_FERR = rx_ferr;
   assign RX_BUSY = (state != S_IDLE);

endmodule
